// File: rtl/data_mem_unit_pkg.sv
// Shared encodings for the data memory unit: FSM states, access size and lane enables.
package data_mem_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic size_e size_of(input logic lb, input logic lh);
        unique case ({lh, lb})
            2'b00:   return SZ_WORD;
            2'b01:   return SZ_BYTE;
            2'b10:   return SZ_HALF;
            default: return SZ_ILL;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input size_e sz);
        case (sz)
            SZ_BYTE: return BE_BYTE;
            SZ_HALF: return BE_HALF;
            SZ_WORD: return BE_WORD;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Word array with per-byte write enables and combinational read on the same word index.
module dmem_word_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_unit.sv
// Data memory front end: request/done handshake, little-endian lane steering,
// split handling for halfwords at byte 3, and rejection of illegal/misaligned words.
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        LB,
    input  logic        LH,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] memdata
);

    state_e      state_q, state_d;
    size_e       size_q, size_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cap_q, cap_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] memdata_q, memdata_d;

    logic          ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [1:0]    k;
    size_e         req_size;

    logic unused_addr;
    assign unused_addr = ^addr_q[31:AW+2];

    assign k        = addr_q[1:0];
    assign req_size = size_of(LB, LH);

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cap_d     = cap_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        memdata_d = memdata_q;
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_idx   = addr_q[AW+1:2];
        ram_wdata = wdata_q << {k, 3'b000};

        case (state_q)
            IDLE: begin
                if (req) begin
                    size_d  = req_size;
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (req_size == SZ_ILL || (req_size == SZ_WORD && addr[1:0] != 2'b00)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = ACC1;
                    end
                end
            end
            ACC1: begin
                if (we_q) begin
                    ram_we = 1'b1;
                    ram_be = be_of(size_q) << k;
                end else begin
                    case (size_q)
                        SZ_BYTE: memdata_d = (ram_rdata >> {k, 3'b000}) & 32'h0000_00FF;
                        SZ_HALF: memdata_d = (ram_rdata >> {k, 3'b000}) & 32'h0000_FFFF;
                        default: memdata_d = ram_rdata;
                    endcase
                end
                if (size_q == SZ_HALF && k == 2'd3) begin
                    // Low byte of the result comes from this word; high byte from the next.
                    cap_d     = ram_rdata[31:24];
                    memdata_d = memdata_q;
                    state_d   = ACC2;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            ACC2: begin
                ram_idx   = addr_q[AW+1:2] + AW'(1);
                ram_wdata = {24'h0, wdata_q[15:8]};
                if (we_q) begin
                    ram_we = 1'b1;
                    ram_be = BE_BYTE;
                end else begin
                    memdata_d = {16'h0, ram_rdata[7:0], cap_q};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset landing on the second access must not commit its write.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            size_q    <= SZ_WORD;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            cap_q     <= 8'h0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            memdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cap_q     <= cap_d;
            done_q    <= done_d;
            err_q     <= err_d;
            memdata_q <= memdata_d;
        end
    end

    dmem_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .be   (ram_be),
        .idx  (ram_idx),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign ready   = (state_q == IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign memdata = memdata_q;

endmodule
